// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, controller state encoding,
// S-box table, GF(2^8) xtime and the SubBytes/ShiftRows/MixColumns steps.
// Blocks are packed column-major {A0..A15}; byte 0 occupies bits [127:120].
package aes_pkg;

    localparam int AES_NR = 10;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] get_byte(input logic [127:0] blk,
                                            input int i);
        return blk[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] blk);
        logic [127:0] res;
        res = '0;
        for (int i = 0; i < 16; i++) begin
            res[127-8*i -: 8] = sbox(get_byte(blk, i));
        end
        return res;
    endfunction

    // Row r of column c takes the byte from column (c+r) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] blk);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127-8*(r+4*c) -: 8] = get_byte(blk, r + 4*((c+r)%4));
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] blk);
        logic [127:0] res;
        logic [7:0]   a0, a1, a2, a3;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = get_byte(blk, 4*c);
            a1 = get_byte(blk, 4*c+1);
            a2 = get_byte(blk, 4*c+2);
            a3 = get_byte(blk, 4*c+3);
            res[127-32*c -: 32] = {
                xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
            };
        end
        return res;
    endfunction

endpackage

// File: rtl/aes128_key_step.sv
// Combinational AES-128 key schedule step: (rk, rcon) -> next round key.
// Ports: rk (current key), rcon (round constant), rk_next (next round key).
module aes128_key_step
    import aes_pkg::*;
(
    input  logic [127:0] rk,
    input  logic [7:0]   rcon,
    output logic [127:0] rk_next
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_sub;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = rk[127:96];
    assign w1 = rk[95:64];
    assign w2 = rk[63:32];
    assign w3 = rk[31:0];

    // SubWord(RotWord(w3)) with rcon folded into the leading byte.
    assign rot_sub = {
        sbox(w3[23:16]) ^ rcon,
        sbox(w3[15:8]),
        sbox(w3[7:0]),
        sbox(w3[31:24])
    };

    assign n0 = w0 ^ rot_sub;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign rk_next = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryption controller, one round per clock, keys on the fly.
// Ports: clk/rst_n, in_valid/in_ready/in_text/in_key, out_valid/out_ready/out_text,
// busy, round; in_key_reuse only when AES128_KEY_REUSE_EN is defined (last-key reuse).
module aes128_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR    = AES_NR,
    parameter int BLK_W = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_text,
    input  logic [BLK_W-1:0] in_key,
`ifdef AES128_KEY_REUSE_EN
    input  logic             in_key_reuse,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_text,
    output logic             busy,
    output logic [3:0]       round
);

    if (NR != 10 || BLK_W != 128) begin : g_cfg_err
        $error("aes128_round_ctrl: only NR=10 and BLK_W=128 are supported");
    end

    localparam logic [3:0] LAST_R = 4'(NR);

    state_e       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   round_q, round_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] out_text_q, out_text_d;

    logic [127:0] sr_sb;
    logic [127:0] mc;
    logic [127:0] rk_next;
    logic [127:0] key_sel;
    logic         accept;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;

`ifdef AES128_KEY_REUSE_EN
    logic [127:0] last_key_q, last_key_d;

    assign key_sel = in_key_reuse ? last_key_q : in_key;
    // Keep the key that was actually used so a reuse chain stays stable.
    assign last_key_d = accept ? key_sel : last_key_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_key_q <= '0;
        end else begin
            last_key_q <= last_key_d;
        end
    end
`else
    assign key_sel = in_key;
`endif

    assign sr_sb = shift_rows(sub_bytes(st_q));
    assign mc    = mix_columns(sr_sb);

    aes128_key_step u_key_step (
        .rk      (rk_q),
        .rcon    (rcon_q),
        .rk_next (rk_next)
    );

    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        rk_d        = rk_q;
        rcon_d      = rcon_q;
        round_d     = round_q;
        out_valid_d = out_valid_q;
        out_text_d  = out_text_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    st_d    = in_text ^ key_sel;
                    rk_d    = key_sel;
                    rcon_d  = 8'h01;
                    round_d = 4'd1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                // Final round skips MixColumns.
                st_d   = ((round_q == LAST_R) ? sr_sb : mc) ^ rk_next;
                rk_d   = rk_next;
                rcon_d = xtime(rcon_q);
                if (round_q == LAST_R) begin
                    state_d = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            DONE: begin
                // First DONE cycle registers the result; then wait for handshake.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_text_d  = st_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    round_d     = 4'd0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            st_q        <= '0;
            rk_q        <= '0;
            rcon_q      <= '0;
            round_q     <= '0;
            out_valid_q <= 1'b0;
            out_text_q  <= '0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            rk_q        <= rk_d;
            rcon_q      <= rcon_d;
            round_q     <= round_d;
            out_valid_q <= out_valid_d;
            out_text_q  <= out_text_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_text  = out_text_q;
    assign busy      = (state_q != IDLE);
    assign round     = round_q;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Self-checking bench for aes128_round_ctrl: FIPS-197 vectors, backpressure,
// mid-round reset and back-to-back traffic against a byte-level AES reference.
module tb_aes128_round_ctrl;

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_key_reuse = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_text = '0;
    logic [127:0] in_key = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [127:0] out_text;
    logic [3:0]   round;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;

    logic [7:0] sb_tab [256];

    aes128_round_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_text      (in_text),
        .in_key       (in_key),
`ifdef AES128_KEY_REUSE_EN
        .in_key_reuse (in_key_reuse),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_text     (out_text),
        .busy         (busy),
        .round        (round)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // GF(2^8) multiply, polynomial 0x11B, by shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] s;
        inv = 8'h00;
        for (int v = 1; v < 256; v++) begin
            if (gmul(x, 8'(v)) == 8'h01) inv = 8'(v);
        end
        s = 8'h63;
        for (int k = 0; k < 5; k++) begin
            s ^= (inv << k) | (inv >> (8 - k));
        end
        return s;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt,
                                             input logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   k [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            k[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ k[i];
        end
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            t[0] = sb_tab[k[13]] ^ rc;
            t[1] = sb_tab[k[14]];
            t[2] = sb_tab[k[15]];
            t[3] = sb_tab[k[12]];
            for (int j = 0; j < 4; j++) k[j] ^= t[j];
            for (int j = 4; j < 16; j++) k[j] ^= k[j-4];
            rc = gmul(rc, 8'h02);
            for (int i = 0; i < 16; i++) t[i] = sb_tab[s[i]];
            for (int c = 0; c < 4; c++) begin
                for (int w = 0; w < 4; w++) begin
                    s[w+4*c] = t[w + 4*((c+w)%4)];
                end
            end
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c];
                    a1 = s[4*c+1];
                    a2 = s[4*c+2];
                    a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= k[i];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Transaction-level model: cycles elapsed since accept decide the outputs.
    bit           m_busy = 1'b0;
    bit           m_ov = 1'b0;
    int           m_cnt = 0;
    int           m_round = 0;
    logic [127:0] m_ot = '0;
    logic [127:0] m_exp = '0;
    logic [127:0] m_last = '0;
    logic [127:0] m_key;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_ov = 1'b0;
            m_cnt = 0;
            m_round = 0;
            m_ot = '0;
            m_last = '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_key = in_key;
`ifdef AES128_KEY_REUSE_EN
                if (in_key_reuse) m_key = m_last;
`endif
                m_last = m_key;
                m_exp = aes_ref(in_text, m_key);
                m_busy = 1'b1;
                m_cnt = 0;
                m_round = 1;
            end
        end else if (m_ov && out_ready) begin
            m_busy = 1'b0;
            m_ov = 1'b0;
            m_round = 0;
        end else begin
            m_cnt++;
            m_round = (m_cnt + 1 > 10) ? 10 : m_cnt + 1;
            if (m_cnt == 11) begin
                m_ov = 1'b1;
                m_ot = m_exp;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 128'(in_ready), 128'(!m_busy));
            chk("busy", 128'(busy), 128'(m_busy));
            chk("round", 128'(round), 128'(m_round));
            chk("out_valid", 128'(out_valid), 128'(m_ov));
            if (m_ov) chk("out_text", out_text, m_ot);
        end
    end

    task automatic send(input logic [127:0] t, input logic [127:0] k,
                        input bit keep);
        int n;
        n = 0;
        in_text = t;
        in_key = k;
        in_valid = 1'b1;
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tmo("send");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            acc_cyc = cyc;
            if (!keep) in_valid = 1'b0;
        end
    endtask

    task automatic wait_out(output int lat, output logic [127:0] txt);
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) tmo("wait_out");
        lat = cyc - acc_cyc;
        txt = out_text;
    endtask

    initial begin
        int lat;
        int n;
        int acc [3];
        logic [127:0] txt;
        logic [127:0] pts [3];
        logic [127:0] keys [3];

        for (int v = 0; v < 256; v++) sb_tab[v] = m_sbox(8'(v));
        chk("model_sbox_00", 128'(sb_tab[0]), 128'h63);
        chk("model_sbox_53", 128'(sb_tab[8'h53]), 128'hed);
        chk("model_app_b", aes_ref(PT_B, KEY_B), CT_B);
        chk("model_app_c", aes_ref(PT_C, KEY_C), CT_C);
        chk("model_zero", aes_ref('0, '0), CT_Z);

        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_text", out_text, '0);
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_round", 128'(round), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        // App.B with latency pin
        send(PT_B, KEY_B, 1'b0);
        wait_out(lat, txt);
        chk("appb_latency", 128'(lat), 128'(11));
        chk("appb_text", txt, CT_B);
        @(negedge clk);

        // App.C
        send(PT_C, KEY_C, 1'b0);
        wait_out(lat, txt);
        chk("appc_text", txt, CT_C);
        @(negedge clk);

        // Backpressure with a second request pending
        out_ready = 1'b0;
        send(PT_B, KEY_B, 1'b1);
        in_text = PT_C;
        in_key = KEY_C;
        wait_out(lat, txt);
        chk("bp_text", txt, CT_B);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 128'(out_valid), 128'(1));
            chk("bp_hold_text", out_text, CT_B);
            chk("bp_in_ready", 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        in_valid = 1'b0;
        wait_out(lat, txt);
        chk("bp_second_text", txt, CT_C);
        @(negedge clk);

        // Reset in round 5
        send(PT_C, KEY_C, 1'b0);
        n = 0;
        while (round != 4'd5 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (round != 4'd5) tmo("reach_round5");
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_out_text", out_text, '0);
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_round", 128'(round), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(PT_B, KEY_B, 1'b0);
        wait_out(lat, txt);
        chk("post_rst_text", txt, CT_B);
        @(negedge clk);

        // Back-to-back, in_valid held high
        pts[0] = PT_B;
        keys[0] = KEY_B;
        pts[1] = PT_C;
        keys[1] = KEY_C;
        pts[2] = '0;
        keys[2] = '0;
        for (int v = 0; v < 3; v++) begin
            send(pts[v], keys[v], 1'b1);
            acc[v] = acc_cyc;
        end
        in_valid = 1'b0;
        wait_out(lat, txt);
        chk("b2b_last_text", txt, CT_Z);
        chk("b2b_period_01", 128'(acc[1] - acc[0]), 128'(13));
        chk("b2b_period_12", 128'(acc[2] - acc[1]), 128'(13));
        @(negedge clk);

`ifdef AES128_KEY_REUSE_EN
        send(PT_B, KEY_B, 1'b0);
        wait_out(lat, txt);
        chk("reuse_first_text", txt, CT_B);
        @(negedge clk);
        in_key_reuse = 1'b1;
        send(PT_B, '0, 1'b0);
        in_key_reuse = 1'b0;
        wait_out(lat, txt);
        chk("reuse_text", txt, CT_B);
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
